// File: rtl/fifo_pkg.sv
// Shared defaults, FSM state type and counter-width helper for the FIFO burst reader.
package fifo_pkg;

  localparam int BW_DEF     = 8;
  localparam int LGFLEN_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// Downstream output register: loads on a FIFO pop, holds while stalled, drops valid on accept.
module fifo_out_reg
  import fifo_pkg::*;
#(
  parameter int BW = BW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_load,
  input  logic [BW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [BW-1:0] o_data
);

  // The reader only pops when the register is empty or being drained,
  // so a load never overwrites a word the consumer has not taken.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Burst reader draining a show-ahead FIFO into a valid/ready stream.
// Define FIFO_READER_TIMEOUT_EN to also flush partial bursts after TIMEOUT idle cycles.
module fifo_reader #(
  parameter int BW      = fifo_pkg::BW_DEF,
  parameter int LGFLEN  = fifo_pkg::LGFLEN_DEF,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [BW-1:0]   i_fifo_data,
  input  logic            i_fifo_empty,
  input  logic [LGFLEN:0] i_fifo_fill,
  output logic            o_fifo_rd,
  output logic            o_valid,
  output logic [BW-1:0]   o_data,
  input  logic            i_ready,
  output logic            o_busy
);

  localparam int              RW         = fifo_pkg::cnt_w(BURST);
  localparam logic [LGFLEN:0] BURST_FILL = (LGFLEN+1)'(BURST);
  localparam logic [RW-1:0]   BURST_CNT  = RW'(BURST);

  if (BURST < 1 || BURST > (1 << LGFLEN)) begin : g_bad_burst
    $error("fifo_reader: BURST must be in 1..(1<<LGFLEN)");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_reader: TIMEOUT must be at least 1");
  end

  // States are package-qualified: the BURST parameter shares its name with a state.
  fifo_pkg::state_t r_state, w_next;
  logic [RW-1:0]    r_remain;
  logic             w_go_full, w_go_part, w_rd, w_valid;

  assign w_go_full = (i_fifo_fill >= BURST_FILL);

`ifdef FIFO_READER_TIMEOUT_EN
  localparam int            WW          = fifo_pkg::cnt_w(TIMEOUT);
  localparam logic [WW-1:0] TIMEOUT_CNT = WW'(TIMEOUT);

  logic [WW-1:0] r_wait;

  // Held at zero outside IDLE, so every IDLE visit starts a fresh wait.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_wait <= '0;
    else if (r_state != fifo_pkg::IDLE || i_fifo_fill == '0)
      r_wait <= '0;
    else if (r_wait != TIMEOUT_CNT)
      r_wait <= r_wait + 1'b1;
  end

  assign w_go_part = !w_go_full && (r_wait == TIMEOUT_CNT) && (i_fifo_fill != '0);
`else
  assign w_go_part = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= fifo_pkg::IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      fifo_pkg::IDLE:
        if (w_go_full || w_go_part) w_next = fifo_pkg::BURST;
      fifo_pkg::BURST:
        if (r_remain == '0 || (r_remain == RW'(1) && w_rd)) w_next = fifo_pkg::IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == fifo_pkg::BURST);
    w_rd   = (r_state == fifo_pkg::BURST) && (r_remain != '0) && !i_fifo_empty &&
             (!w_valid || i_ready);
  end

  // A partial load only happens with fill < BURST, so it fits in RW bits.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_remain <= '0;
    else if (r_state == fifo_pkg::IDLE) begin
      if (w_go_full)      r_remain <= BURST_CNT;
      else if (w_go_part) r_remain <= RW'(i_fifo_fill);
    end else if (w_rd)
      r_remain <= r_remain - 1'b1;
  end

  fifo_out_reg #(.BW(BW)) u_out (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (w_rd),
    .i_data    (i_fifo_data),
    .i_ready   (i_ready),
    .o_valid   (w_valid),
    .o_data    (o_data)
  );

  assign o_fifo_rd = w_rd;
  assign o_valid   = w_valid;

endmodule
